// File: rtl/cycle_fifo_pkg.sv
// cycle_fifo_pkg
//   Shared constants and helpers for the cycle_fifo block.
//   Build-time macros (each may be predefined on the command line):
//     LEN_CYCLE_REG       default FIFO depth (power of two, >= 2)
//     LEN_CYCLE_REG_ADDR  log2 of LEN_CYCLE_REG
//     CYCLE_FIFO_DROP_W   width of the rejected-push counter (16)
//     CYCLE_FIFO_DROP_CNT_EN  when defined, cycle_fifo exposes drop_count
//   No ports; this file only holds declarations.

`ifndef LEN_CYCLE_REG
`define LEN_CYCLE_REG 16
`endif
`ifndef LEN_CYCLE_REG_ADDR
`define LEN_CYCLE_REG_ADDR 4
`endif
`ifndef CYCLE_FIFO_DROP_W
`define CYCLE_FIFO_DROP_W 16
`endif

package cycle_fifo_pkg;

    localparam int DROP_W = `CYCLE_FIFO_DROP_W;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cycle_fifo_mem.sv
// cycle_fifo_mem
//   DEPTH x WIDTH simple dual-port register array.
//   Write port is synchronous and enable-gated. The read port is registered:
//   rd_data loads mem[rd_addr] on a rising edge with rd_en high and holds
//   otherwise. Only the read register is reset; the array itself is not.
//   When the same address is written and read on one edge, rd_data returns
//   the word stored before that edge.
// Ports:
//   clk      in   clock
//   rstn     in   synchronous active-low reset (read register only)
//   wr_en    in   write enable
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_en    in   read enable
//   rd_addr  in   read address
//   rd_data  out  registered read data

module cycle_fifo_mem
    import cycle_fifo_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/cycle_fifo.sv
// cycle_fifo
//   Parametrised circular FIFO using all DEPTH slots, with occupancy,
//   full/empty flags and a synchronous flush.
//   Optional feature macro: CYCLE_FIFO_DROP_CNT_EN adds drop_count, a
//   saturating count of pushes rejected because the FIFO was full.
// Ports:
//   clk         in   clock
//   rstn        in   synchronous active-low reset
//   i_order     in   push request (level)
//   i_data      in   push data
//   i_done      out  one-cycle pulse: push accepted on the last edge
//   o_order     in   pop request (level)
//   o_data      out  popped word, held until the next accepted pop
//   o_done      out  one-cycle pulse: o_data updated on the last edge
//   flush       in   synchronous clear of pointers and occupancy
//   count       out  occupancy 0..DEPTH
//   full        out  count == DEPTH
//   empty       out  count == 0
//   drop_count  out  rejected pushes, saturating (macro builds only)
//
// Handshake: i_order / o_order are level requests sampled on every rising
// edge; an accepted request is acknowledged by a single-cycle done pulse in
// the following cycle. A requester that holds its order high gets one
// transfer per edge for as long as the FIFO can accept/supply, and counts
// done pulses to know how many went through. Nothing is accepted on a cycle
// where rstn is low or flush is high.

`ifndef LEN_CYCLE_REG
`define LEN_CYCLE_REG 16
`endif
`ifndef LEN_CYCLE_REG_ADDR
`define LEN_CYCLE_REG_ADDR 4
`endif

module cycle_fifo
    import cycle_fifo_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = `LEN_CYCLE_REG,
    parameter int LENGTH_ADDR = `LEN_CYCLE_REG_ADDR
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   i_order,
    input  logic [WIDTH-1:0]       i_data,
    output logic                   i_done,
    input  logic                   o_order,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_done,
    input  logic                   flush,
    output logic [LENGTH_ADDR:0]   count,
`ifdef CYCLE_FIFO_DROP_CNT_EN
    output logic                   full,
    output logic                   empty,
    output logic [DROP_W-1:0]      drop_count
`else
    output logic                   full,
    output logic                   empty
`endif
);

    localparam logic [LENGTH_ADDR-1:0] PTR_ONE  = LENGTH_ADDR'(1);
    localparam logic [LENGTH_ADDR:0]   CNT_ONE  = (LENGTH_ADDR + 1)'(1);
    localparam logic [LENGTH_ADDR:0]   CNT_FULL = (LENGTH_ADDR + 1)'(DEPTH);

    logic [LENGTH_ADDR-1:0] wr_ptr;
    logic [LENGTH_ADDR-1:0] rd_ptr;
    logic [LENGTH_ADDR:0]   cnt;
    logic                   active;
    logic                   push_ok;
    logic                   pop_ok;

    assign count = cnt;
    assign full  = (cnt == CNT_FULL);
    assign empty = (cnt == '0);

    // Reset and flush both swallow any request issued in the same cycle.
    assign active  = rstn && !flush;
    assign pop_ok  = active && o_order && !empty;
    // A full FIFO still takes a push when a pop frees the slot this edge;
    // since wr_ptr == rd_ptr when full, the memory reads the old word out
    // while the new one is written into the same slot.
    assign push_ok = active && i_order && (!full || pop_ok);

    cycle_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (LENGTH_ADDR)
    ) u_mem (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data (i_data),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr),
        .rd_data (o_data)
    );

    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            i_done <= 1'b0;
            o_done <= 1'b0;
        end else begin
            i_done <= push_ok;
            o_done <= pop_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef CYCLE_FIFO_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            drop_count <= '0;
        end else if (i_order && !push_ok) begin
            drop_count <= sat_inc(drop_count);
        end
    end
`endif

endmodule

// File: tb/tb_cycle_fifo.sv
// tb_cycle_fifo
//   Directed bench for cycle_fifo at DEPTH=4, WIDTH=8. A queue-based model
//   tracks the expected FIFO contents and outputs; a compare process checks
//   every output on each falling edge, and the directed sequences add
//   hand-computed literal expectations.

module tb_cycle_fifo;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AW = 2;

    logic          clk;
    logic          rstn;
    logic          i_order;
    logic [W-1:0]  i_data;
    logic          i_done;
    logic          o_order;
    logic [W-1:0]  o_data;
    logic          o_done;
    logic          flush;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
`ifdef CYCLE_FIFO_DROP_CNT_EN
    logic [15:0]   drop_count;
`endif

    cycle_fifo #(
        .WIDTH       (W),
        .DEPTH       (D),
        .LENGTH_ADDR (AW)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .i_order (i_order),
        .i_data  (i_data),
        .i_done  (i_done),
        .o_order (o_order),
        .o_data  (o_data),
        .o_done  (o_done),
        .flush   (flush),
        .count   (count),
        .full    (full),
`ifdef CYCLE_FIFO_DROP_CNT_EN
        .empty   (empty),
        .drop_count (drop_count)
`else
        .empty   (empty)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_odata;
    logic         m_idone;
    logic         m_odone;
    logic [15:0]  m_drop;
    bit           model_live = 0;

    always @(posedge clk) begin
        bit do_pop;
        bit do_push;
        if (!rstn) begin
            exp_q.delete();
            m_odata    = '0;
            m_idone    = 1'b0;
            m_odone    = 1'b0;
            m_drop     = '0;
            model_live = 1;
        end else if (flush) begin
            exp_q.delete();
            m_idone = 1'b0;
            m_odone = 1'b0;
            m_drop  = '0;
        end else begin
            do_pop  = o_order && (exp_q.size() > 0);
            do_push = i_order && ((exp_q.size() < D) || do_pop);
            m_idone = do_push;
            m_odone = do_pop;
            if (do_pop)  m_odata = exp_q.pop_front();
            if (do_push) exp_q.push_back(i_data);
            if (i_order && !do_push && m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end
    end

    // Compare every output on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (model_live) begin
            chk("i_done", {31'd0, i_done}, {31'd0, m_idone});
            chk("o_done", {31'd0, o_done}, {31'd0, m_odone});
            chk("o_data", {24'd0, o_data}, {24'd0, m_odata});
            chk("count",  {29'd0, count},  exp_q.size());
            chk("full",   {31'd0, full},   {31'd0, exp_q.size() == D});
            chk("empty",  {31'd0, empty},  {31'd0, exp_q.size() == 0});
`ifdef CYCLE_FIFO_DROP_CNT_EN
            chk("drop_count", {16'd0, drop_count}, {16'd0, m_drop});
`endif
        end
    end

    // ---------------- driver ----------------
    // Called 2 time units after a rising edge; applies inputs for one edge
    // and returns 2 time units after that edge, with outputs settled.
    task automatic cyc(input logic push, input logic [W-1:0] d, input logic pop, input logic fl);
        i_order = push;
        i_data  = d;
        o_order = pop;
        flush   = fl;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rstn    = 1'b0;
        i_order = 1'b0;
        i_data  = '0;
        o_order = 1'b0;
        flush   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst o_data", {24'd0, o_data}, 32'h0);
        chk("rst count", {29'd0, count}, 32'd0);
        chk("rst empty", {31'd0, empty}, 32'd1);
        chk("rst full", {31'd0, full}, 32'd0);
        chk("rst i_done", {31'd0, i_done}, 32'd0);
        rstn = 1'b1;

        // Three pushes then three pops.
        cyc(1'b1, 8'h11, 1'b0, 1'b0);
        chk("t1 i_done", {31'd0, i_done}, 32'd1);
        cyc(1'b1, 8'h22, 1'b0, 1'b0);
        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        chk("t1 count3", {29'd0, count}, 32'd3);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t1 pop0", {24'd0, o_data}, 32'h11);
        chk("t1 o_done", {31'd0, o_done}, 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t1 pop1", {24'd0, o_data}, 32'h22);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t1 pop2", {24'd0, o_data}, 32'h33);
        chk("t1 empty", {31'd0, empty}, 32'd1);
        idle();
        chk("t1 hold", {24'd0, o_data}, 32'h33);
        chk("t1 no o_done", {31'd0, o_done}, 32'd0);

        // Overfill: five pushes into a four-slot FIFO.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
            chk("t2 i_done", {31'd0, i_done}, (i < 4) ? 32'd1 : 32'd0);
        end
        chk("t2 full", {31'd0, full}, 32'd1);
        chk("t2 count", {29'd0, count}, 32'd4);
`ifdef CYCLE_FIFO_DROP_CNT_EN
        chk("t2 drop", {16'd0, drop_count}, 32'd1);
`endif
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("t2 pop", {24'd0, o_data}, 32'hA0 + i);
        end

        // Full FIFO with simultaneous push and pop.
        for (int i = 1; i <= 4; i++) cyc(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'hB5, 1'b1, 1'b0);
        chk("t3 i_done", {31'd0, i_done}, 32'd1);
        chk("t3 o_done", {31'd0, o_done}, 32'd1);
        chk("t3 o_data", {24'd0, o_data}, 32'hB1);
        chk("t3 count", {29'd0, count}, 32'd4);
        for (int i = 2; i <= 5; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("t3 pop", {24'd0, o_data}, 32'hB0 + i);
        end

        // Empty FIFO with simultaneous push and pop: no fall-through.
        cyc(1'b1, 8'hC1, 1'b1, 1'b0);
        chk("t4 i_done", {31'd0, i_done}, 32'd1);
        chk("t4 o_done", {31'd0, o_done}, 32'd0);
        chk("t4 o_data", {24'd0, o_data}, 32'hB5);
        chk("t4 count", {29'd0, count}, 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4 pop", {24'd0, o_data}, 32'hC1);

        // Pointer wrap: 3*DEPTH push/pop pairs, FIFO held at one entry.
        cyc(1'b1, 8'h40, 1'b0, 1'b0);
        for (int i = 0; i < 3 * D; i++) begin
            cyc(1'b1, 8'h41 + 8'(i), 1'b1, 1'b0);
            chk("t5 pop", {24'd0, o_data}, 32'h40 + i);
            chk("t5 count", {29'd0, count}, 32'd1);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t5 last", {24'd0, o_data}, 32'h4C);

        // Flush with count=3 and a concurrent push.
        for (int i = 1; i <= 3; i++) cyc(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'h64, 1'b0, 1'b1);
        chk("t6 count", {29'd0, count}, 32'd0);
        chk("t6 empty", {31'd0, empty}, 32'd1);
        chk("t6 i_done", {31'd0, i_done}, 32'd0);
        chk("t6 o_data", {24'd0, o_data}, 32'h4C);
`ifdef CYCLE_FIFO_DROP_CNT_EN
        chk("t6 drop", {16'd0, drop_count}, 32'd0);
`endif
        cyc(1'b1, 8'h71, 1'b0, 1'b0);
        cyc(1'b1, 8'h72, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t6 post pop", {24'd0, o_data}, 32'h71);

        // Reset mid-stream with both requests held.
        rstn = 1'b0;
        cyc(1'b1, 8'h80, 1'b1, 1'b0);
        chk("t7 o_data", {24'd0, o_data}, 32'h0);
        chk("t7 count", {29'd0, count}, 32'd0);
        chk("t7 o_done", {31'd0, o_done}, 32'd0);
        chk("t7 i_done", {31'd0, i_done}, 32'd0);
        rstn = 1'b1;
        cyc(1'b1, 8'h91, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t7 recover", {24'd0, o_data}, 32'h91);
        idle();
        idle();

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
